bmp_pixel_sink: RTL
===================

// Module: bmp_pixel_sink
// PURPOSE
// - FPGA-side consumer of the 32-bit bitmap pixel stream that Nios software writes to the bmp_pixout PIO.
// - Detects each new PIO word with a toggle handshake and returns a toggle acknowledge on a PIO input.
// - Buffers words in a small FIFO and writes them to sprite/background pixel RAM at sequential addresses.
// - The VGA pixel path reads that RAM; this block is the write end of the software->video image link.
// PARAMETERS
// - IMG_W       64    image width in pixels
// - IMG_H       64    image height in pixels
// - NUM_PIX     IMG_W*IMG_H, i.e. 4096 pixels per image
// - ADDR_W      12    RAM address width; must satisfy 2**ADDR_W >= NUM_PIX
// - FIFO_DEPTH  4     pixel FIFO entries; power of 2, minimum 2
// PORTS
// - Clk           in   1       system clock; the Nios system runs on the same clock
// - Reset_n       in   1       asynchronous, active-low reset
// - pio_word      in   32      [23:0] RGB888 pixel, [24] strobe toggle, [25] SOF (start of image), [31:26] ignored
// - pio_ack       out  1       acknowledge toggle; equals the strobe value of the last accepted word
// - pix_wr_en     out  1       RAM write strobe
// - pix_wr_addr   out  ADDR_W  RAM write address
// - pix_wr_data   out  PIX_W   pixel data; PIX_W = 24, or 16 with RGB565 enabled
// - pix_wr_ready  in   1       RAM accepts the write this cycle (VGA-read arbitration)
// - load_done     out  1       full image written; level output
// - load_err      out  1       sticky protocol error; cleared by the next SOF
// BEHAVIOUR
// - Reset values:
//   - pio_ack = 0, pix_wr_en = 0, pix_wr_addr = 0, pix_wr_data = 0.
//   - load_done = 0, load_err = 0, FIFO empty, state = IDLE, last_strobe = 0.
// - Input handling:
//   - pio_word is registered once (cycle N -> N+1).
//   - new_word = (reg_strobe != last_strobe).
// - Accept rule:
//   - A new word is accepted in cycle N+1 if the FIFO is not full.
//   - On accept: last_strobe <= reg_strobe, pio_ack <= reg_strobe (visible in cycle N+2), and the word is pushed as {SOF, RGB}.
//   - If the FIFO is full, nothing is updated; the word stays pending and is accepted once space exists. Software stalls on the ack.
// - States (they track the word being pushed):
//   - IDLE:
//     - SOF word: push it, go to LOAD.
//     - Non-SOF word: ack it, discard it, set load_err.
//   - LOAD:
//     - Push every word.
//     - When NUM_PIX pixels are counted since the last SOF, go to DONE.
//   - DONE:
//     - Non-SOF word: ack it, discard it, set load_err.
//     - SOF word: push it, go to LOAD.
//   - Any SOF word, in any state, clears load_err and load_done and restarts the push-side count at 1.
// - Write side:
//   - When the FIFO is non-empty and pix_wr_en is low, or a write completed this cycle, present the head entry with pix_wr_en = 1.
//   - The head entry is popped when pix_wr_en && pix_wr_ready.
//   - Hold pix_wr_en, pix_wr_addr and pix_wr_data stable while pix_wr_ready = 0.
//   - Address: an SOF entry writes at address 0; every later entry writes at the previous address + 1.
//   - Addresses never exceed NUM_PIX-1, because the push side discards excess pixels.
//   - load_done rises the cycle after the write to NUM_PIX-1 completes. It stays high until the next SOF is popped.
// - Latency: strobe toggle in cycle N, with the FIFO empty and ready = 1:
//   - ack toggles in N+2.
//   - pix_wr_en is high in N+2.
//   - Throughput is 1 pixel per cycle.
// - Simultaneous push and pop with the FIFO full: the pop frees a slot only in the next cycle (no bypass).
// - Reset mid-image: all state returns to reset values; the partial image is abandoned; RAM contents are untouched.
// - Software must restart with an SOF word whose strobe differs from 0.
// CONFIGURATION
// - VEGGIE_RGB565_EN defined:
//   - PIX_W = 16; pix_wr_data = {R[7:3], G[7:2], B[7:3]}, truncation only.
// - VEGGIE_RGB565_EN undefined:
//   - PIX_W = 24; pix_wr_data = RGB888 unchanged.
// TESTING
// - Reset, SOF word 0x03_FF0000 (strobe 1), ready = 1:
//   - pio_ack = 1 two cycles later.
//   - Write addr 0, data 0xFF0000.
// - Full image: 4096 words, alternating strobe, first word SOF:
//   - 4096 writes at addr 0..4095.
//   - load_done = 1 after the last write; load_err = 0.
// - Non-SOF word 0x01_00FF00 while IDLE:
//   - ack toggles, no write, load_err = 1.
//   - Next SOF clears load_err.
// - pix_wr_ready = 0 for 20 cycles during a load, with 6 words offered:
//   - 4 acks, then ack stalls.
//   - Outputs are held stable.
//   - After ready returns, all 6 words are written in order, with no loss.
// - SOF at pixel 100 of a load:
//   - Pixels 0..99 are written, then the next write goes to addr 0.
//   - load_done stays 0.
// - Reset_n low mid-load, then high: all outputs are 0 and state is IDLE. With VEGGIE_RGB565_EN, pixel 0x FF8040 writes 0xFC08.

Source files
------------

// File: rtl/bmp_pixel_sink_if.sv
// Bus between the Nios PIO, the bitmap pixel sink and the pixel RAM write port.
// Macro VEGGIE_RGB565_EN narrows pix_wr_data to 16-bit RGB565.
interface bmp_pixel_sink_if #(
  parameter int ADDR_W = 12
);
`ifdef VEGGIE_RGB565_EN
  localparam int PIX_W = 16;
`else
  localparam int PIX_W = 24;
`endif

  // PIO: a word is new when bit 24 differs from the last accepted strobe; pio_ack
  // echoes that strobe once accepted. RAM: a write completes in every cycle with
  // pix_wr_en && pix_wr_ready; en/addr/data stay put while ready is low.
  logic [31:0]       pio_word;
  logic              pio_ack;
  logic              pix_wr_en;
  logic [ADDR_W-1:0] pix_wr_addr;
  logic [PIX_W-1:0]  pix_wr_data;
  logic              pix_wr_ready;
  logic              load_done;
  logic              load_err;

  modport master (
    output pio_word, pix_wr_ready,
    input  pio_ack, pix_wr_en, pix_wr_addr, pix_wr_data, load_done, load_err
  );

  modport slave (
    input  pio_word, pix_wr_ready,
    output pio_ack, pix_wr_en, pix_wr_addr, pix_wr_data, load_done, load_err
  );
endinterface

// File: rtl/bmp_pixel_sink.sv
// Write end of the software->video bitmap link: toggle-handshaked PIO words go through
// a small FIFO into pixel RAM. Macro VEGGIE_RGB565_EN selects RGB565 output data.
module bmp_pixel_sink #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  bmp_pixel_sink_if.slave bus,
  output logic [1:0]      state_dbg
);
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PCNT_W  = $clog2(NUM_PIX + 1);
`ifdef VEGGIE_RGB565_EN
  localparam int PIX_W = 16;
`else
  localparam int PIX_W = 24;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [25:0]       reg_word;
  logic              last_strobe;
  logic [PCNT_W-1:0] push_cnt;
  logic [24:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              cur_sof;

  logic        reg_strobe, reg_sof, new_word, fifo_full, accept, push, pop;
  logic        load_slot, from_fifo, nxt_valid;
  logic [24:0] push_entry, nxt_entry;
  logic [5:0]  unused_pio;

  function automatic logic [PIX_W-1:0] to_pix(input logic [23:0] rgb);
`ifdef VEGGIE_RGB565_EN
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
`else
    return rgb;
`endif
  endfunction

  assign unused_pio = bus.pio_word[31:26];
  assign state_dbg  = state;

  assign reg_strobe = reg_word[24];
  assign reg_sof    = reg_word[25];
  assign push_entry = {reg_sof, reg_word[23:0]};
  assign new_word   = reg_strobe != last_strobe;
  assign fifo_full  = fifo_cnt == CNT_W'(FIFO_DEPTH);
  assign accept     = new_word && !fifo_full;
  assign push       = accept && (reg_sof || state == LOAD);
  assign pop        = bus.pix_wr_en && bus.pix_wr_ready;

  // The presented entry stays counted in the FIFO until its write completes, so the
  // next candidate sits one slot past rd_ptr while pix_wr_en is high. When the FIFO
  // holds nothing beyond that, the word being pushed this cycle goes straight out.
  assign load_slot = !bus.pix_wr_en || pop;
  assign from_fifo = fifo_cnt > CNT_W'(bus.pix_wr_en);
  assign nxt_valid = from_fifo || push;
  assign nxt_entry = from_fifo ? fifo_mem[rd_ptr + PTR_W'(bus.pix_wr_en)] : push_entry;

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state           <= IDLE;
      reg_word        <= '0;
      last_strobe     <= 1'b0;
      push_cnt        <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fifo_cnt        <= '0;
      cur_sof         <= 1'b0;
      bus.pio_ack     <= 1'b0;
      bus.pix_wr_en   <= 1'b0;
      bus.pix_wr_addr <= '0;
      bus.pix_wr_data <= '0;
      bus.load_done   <= 1'b0;
      bus.load_err    <= 1'b0;
    end else begin
      reg_word <= bus.pio_word[25:0];

      if (accept) begin
        last_strobe <= reg_strobe;
        bus.pio_ack <= reg_strobe;
        if (reg_sof) begin
          bus.load_err <= 1'b0;
          push_cnt     <= PCNT_W'(1);
          state        <= (NUM_PIX == 1) ? DONE : LOAD;
        end else if (state == LOAD) begin
          push_cnt <= push_cnt + 1'b1;
          if (push_cnt == PCNT_W'(NUM_PIX - 1)) state <= DONE;
        end else begin
          bus.load_err <= 1'b1;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      if (load_slot) begin
        bus.pix_wr_en <= nxt_valid;
        if (nxt_valid) begin
          cur_sof         <= nxt_entry[24];
          bus.pix_wr_addr <= nxt_entry[24] ? '0 : bus.pix_wr_addr + 1'b1;
          bus.pix_wr_data <= to_pix(nxt_entry[23:0]);
        end
      end

      // A new image (accepted or reaching RAM) always wins over a stale completion.
      if (pop && bus.pix_wr_addr == LAST_ADDR) bus.load_done <= 1'b1;
      else if (pop && cur_sof)                 bus.load_done <= 1'b0;
      if (accept && reg_sof)                   bus.load_done <= 1'b0;
    end
  end
endmodule
